// File: rtl/btb_update_ctrl.sv
// BTB update controller: queues resolved branches and applies each as a read-modify-write on the shared BTB port.
// Define BTB_STATS_EN to enable the stat_upd/stat_alloc/stat_drop counters (otherwise tied to zero).
module btb_update_ctrl #(
    parameter int DEPTH     = 4,
    parameter int IDX_W     = 4,
    parameter int MAX_DEFER = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 upd_valid,
    input  logic [15:0]          upd_pc,
    input  logic [15:0]          upd_target,
    input  logic                 upd_taken,
    output logic                 upd_full,
    input  logic                 fetch_req,
    input  logic [IDX_W-1:0]     fetch_idx,
    output logic                 fetch_stall,
    output logic                 btb_rd,
    output logic                 btb_wr,
    output logic [IDX_W-1:0]     btb_addr,
    input  logic [34-IDX_W-1:0]  btb_rdata,
    output logic [34-IDX_W-1:0]  btb_wdata,
    output logic [15:0]          stat_upd,
    output logic [15:0]          stat_alloc,
    output logic [15:0]          stat_drop
);
    localparam int TAG_W = 15 - IDX_W;
    localparam int RD_W  = 34 - IDX_W;
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int DEF_W = $clog2(MAX_DEFER + 1);

    typedef enum logic {S_IDLE, S_MODIFY} state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [DEF_W-1:0]   r_defer;
    logic [DEF_W-1:0]   w_defer_nxt;
    logic [CNT_W-1:0]   r_count;
    logic [CNT_W-1:0]   w_count_nxt;
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic               r_full;

    logic [15:1]        r_pc_q  [DEPTH];
    logic [15:0]        r_tgt_q [DEPTH];
    logic [DEPTH-1:0]   r_tkn_q;

    logic               w_push;
    logic               w_pop;
    logic               w_empty;
    logic               w_grant_upd;
    logic [15:1]        w_head_pc;
    logic [IDX_W-1:0]   w_head_idx;
    logic [TAG_W-1:0]   w_head_tag;
    logic [15:0]        w_head_tgt;
    logic               w_head_tkn;
    logic               w_rd_valid;
    logic [TAG_W-1:0]   w_rd_tag;
    logic [15:0]        w_rd_tgt;
    logic [1:0]         w_rd_ctr;
    logic               w_hit;
    logic [1:0]         w_ctr_nxt;
    logic               w_unused_pc0;

    assign w_unused_pc0 = upd_pc[0];

    assign w_push  = upd_valid && !r_full;
    assign w_pop   = (r_state == S_MODIFY);
    assign w_empty = (r_count == '0);
    assign upd_full = r_full;

    assign w_head_pc  = r_pc_q[r_rd_ptr];
    assign w_head_idx = w_head_pc[IDX_W:1];
    assign w_head_tag = w_head_pc[15:IDX_W+1];
    assign w_head_tgt = r_tgt_q[r_rd_ptr];
    assign w_head_tkn = r_tkn_q[r_rd_ptr];

    assign w_rd_valid = btb_rdata[RD_W-1];
    assign w_rd_tag   = btb_rdata[RD_W-2 -: TAG_W];
    assign w_rd_tgt   = btb_rdata[17:2];
    assign w_rd_ctr   = btb_rdata[1:0];
    assign w_hit      = w_rd_valid && (w_rd_tag == w_head_tag);

    always_comb begin
        w_ctr_nxt = w_rd_ctr;
        if (w_head_tkn) begin
            if (w_rd_ctr != 2'b11) w_ctr_nxt = w_rd_ctr + 2'd1;
        end else begin
            if (w_rd_ctr != 2'b00) w_ctr_nxt = w_rd_ctr - 2'd1;
        end
    end

    // The update wins the port when IF is quiet or has already deferred it MAX_DEFER times.
    assign w_grant_upd = !w_empty && (!fetch_req || (r_defer == DEF_W'(MAX_DEFER)));

    always_comb begin
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + CNT_W'(1);
            2'b01:   w_count_nxt = r_count - CNT_W'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_defer  <= '0;
            r_count  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_full   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_defer  <= w_defer_nxt;
            r_count  <= w_count_nxt;
            r_full   <= (w_count_nxt == CNT_W'(DEPTH));
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_pc_q[r_wr_ptr]  <= upd_pc[15:1];
            r_tgt_q[r_wr_ptr] <= upd_target;
            r_tkn_q[r_wr_ptr] <= upd_taken;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_defer_nxt = r_defer;
        case (r_state)
            S_IDLE: begin
                if (w_grant_upd) begin
                    w_state_nxt = S_MODIFY;
                    w_defer_nxt = '0;
                end else if (!w_empty && fetch_req) begin
                    w_defer_nxt = r_defer + DEF_W'(1);
                end
            end
            S_MODIFY: w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        fetch_stall = 1'b0;
        btb_rd      = 1'b0;
        btb_wr      = 1'b0;
        btb_addr    = fetch_idx;
        btb_wdata   = '0;
        case (r_state)
            S_IDLE: begin
                if (w_grant_upd) begin
                    btb_rd      = 1'b1;
                    btb_addr    = w_head_idx;
                    fetch_stall = fetch_req;
                end else begin
                    btb_rd = fetch_req;
                end
            end
            S_MODIFY: begin
                fetch_stall = fetch_req;
                btb_addr    = w_head_idx;
                btb_wr      = w_hit || w_head_tkn;
                if (w_hit)
                    btb_wdata = {1'b1, w_head_tag, (w_head_tkn ? w_head_tgt : w_rd_tgt), w_ctr_nxt};
                else
                    btb_wdata = {1'b1, w_head_tag, w_head_tgt, 2'b10};
            end
            default: ;
        endcase
    end

`ifdef BTB_STATS_EN
    logic [15:0] r_stat_upd;
    logic [15:0] r_stat_alloc;
    logic [15:0] r_stat_drop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat_upd   <= '0;
            r_stat_alloc <= '0;
            r_stat_drop  <= '0;
        end else begin
            if (w_pop && (r_stat_upd != '1))
                r_stat_upd <= r_stat_upd + 16'd1;
            if (w_pop && !w_hit && w_head_tkn && (r_stat_alloc != '1))
                r_stat_alloc <= r_stat_alloc + 16'd1;
            if (upd_valid && r_full && (r_stat_drop != '1))
                r_stat_drop <= r_stat_drop + 16'd1;
        end
    end

    assign stat_upd   = r_stat_upd;
    assign stat_alloc = r_stat_alloc;
    assign stat_drop  = r_stat_drop;
`else
    assign stat_upd   = '0;
    assign stat_alloc = '0;
    assign stat_drop  = '0;
`endif

endmodule
